// File: rtl/router_out_ctrl.sv
// rtl/router_out_ctrl.sv - read-side controller for one router output port
// Optional parity checking is enabled by defining ROUTER_OUT_PARITY_CHK_EN.
module router_out_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       soft_rst,
  input  logic       read_enb,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       pkt_done,
  output logic       hdr_err,
  output logic       parity_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] data_q, data_d;
  logic       hdr_q, hdr_d;
  logic       soft_rst_q, soft_rst_d;
  logic       pkt_done_q, pkt_done_d;
  logic       hdr_err_q, hdr_err_d;
  logic       rd_en;
`ifdef ROUTER_OUT_PARITY_CHK_EN
  logic [7:0] acc_q, acc_d;
  logic       par_err_q, par_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      hdr_q      <= 1'b0;
      soft_rst_q <= 1'b0;
      pkt_done_q <= 1'b0;
      hdr_err_q  <= 1'b0;
`ifdef ROUTER_OUT_PARITY_CHK_EN
      acc_q      <= '0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      hdr_q      <= hdr_d;
      soft_rst_q <= soft_rst_d;
      pkt_done_q <= pkt_done_d;
      hdr_err_q  <= hdr_err_d;
`ifdef ROUTER_OUT_PARITY_CHK_EN
      acc_q      <= acc_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    timer_d    = timer_q;
    data_d     = data_q;
    hdr_d      = hdr_q;
    soft_rst_d = 1'b0;
    pkt_done_d = 1'b0;
    hdr_err_d  = 1'b0;
    rd_en      = 1'b0;
`ifdef ROUTER_OUT_PARITY_CHK_EN
    acc_d      = acc_q;
    par_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The FIFO is being flushed during the soft_rst cycle, so hold off.
        if (!fifo_empty && !soft_rst_q) begin
          rd_en   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        timer_d = '0;
        if (fifo_dout[8]) begin
          hdr_err_d = (rem_q != 7'd0);
          rem_d     = 7'(fifo_dout[7:2]) + 7'd1;
          hdr_d     = 1'b1;
          data_d    = fifo_dout[7:0];
          state_d   = HOLD;
`ifdef ROUTER_OUT_PARITY_CHK_EN
          acc_d     = '0;
`endif
        end else if (rem_q == 7'd0) begin
          hdr_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hdr_d   = 1'b0;
          data_d  = fifo_dout[7:0];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (read_enb) begin
          if (!hdr_q) begin
            rem_d      = rem_q - 7'd1;
            pkt_done_d = (rem_q == 7'd1);
          end
`ifdef ROUTER_OUT_PARITY_CHK_EN
          if (!hdr_q && rem_q == 7'd1) par_err_d = (data_q != acc_q);
          else                         acc_d     = acc_q ^ data_q;
`endif
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == TMO_LAST) begin
          soft_rst_d = 1'b1;
          rem_d      = '0;
          timer_d    = '0;
          state_d    = IDLE;
`ifdef ROUTER_OUT_PARITY_CHK_EN
          acc_d      = '0;
`endif
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = rd_en & rst;
  assign soft_rst   = soft_rst_q;
  assign vld_out    = (state_q == HOLD);
  assign data_out   = data_q;
  assign pkt_done   = pkt_done_q;
  assign hdr_err    = hdr_err_q;
`ifdef ROUTER_OUT_PARITY_CHK_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_ctrl.sv
// tb/tb_router_out_ctrl.sv - directed self-checking bench for router_out_ctrl
// A small behavioural FIFO feeds the DUT; every check runs on the falling edge.
module tb_router_out_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [8:0] fifo_dout = '0;
  logic       fifo_rd_en;
  logic       soft_rst;
  logic       read_enb = 1'b0;
  logic       vld_out;
  logic [7:0] data_out;
  logic       pkt_done;
  logic       hdr_err;
  logic       parity_err;

  int nvec = 0;
  int nerr = 0;

  logic [8:0] mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;

  router_out_ctrl #(.TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .soft_rst(soft_rst), .read_enb(read_enb),
    .vld_out(vld_out), .data_out(data_out), .pkt_done(pkt_done),
    .hdr_err(hdr_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (!rst || soft_rst) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  task automatic push(input logic [8:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    read_enb = 1'b0;
    repeat (3) @(negedge clk);
    push(9'h100);
    #1;
    nvec++;
    if ({vld_out, data_out, fifo_rd_en, soft_rst, pkt_done, hdr_err, parity_err} !== 14'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h expected 0", {vld_out, data_out, fifo_rd_en, soft_rst, pkt_done, hdr_err, parity_err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (vld_out !== 1'b0) begin nerr++; $display("FAIL reset_release_vld: got %b expected 0", vld_out); end
  endtask

  task automatic test_packet();
    logic [7:0] exp_b [5];
    logic       exp_v;
    exp_b = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    push(9'h10C); push(9'h011); push(9'h022); push(9'h033); push(9'h00C);
    read_enb = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 0) && (i <= 10);
      nvec++;
      if (vld_out !== exp_v) begin nerr++; $display("FAIL pkt_vld[%0d]: got %b expected %b", i, vld_out, exp_v); end
      if (exp_v) begin
        nvec++;
        if (data_out !== exp_b[i/2-1]) begin nerr++; $display("FAIL pkt_data[%0d]: got %h expected %h", i, data_out, exp_b[i/2-1]); end
      end
      nvec++;
      if ({pkt_done, parity_err, hdr_err} !== {(i == 11), 2'b00}) begin
        nerr++;
        $display("FAIL pkt_flags[%0d]: got %b expected %b", i, {pkt_done, parity_err, hdr_err}, {(i == 11), 2'b00});
      end
    end
    read_enb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_parity_err();
    logic exp_pe;
`ifdef ROUTER_OUT_PARITY_CHK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    push(9'h10C); push(9'h011); push(9'h022); push(9'h033); push(9'h0FF);
    read_enb = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      nvec++;
      if ({pkt_done, parity_err} !== ((i == 11) ? {1'b1, exp_pe} : 2'b00)) begin
        nerr++;
        $display("FAIL parity_flags[%0d]: got %b expected %b", i, {pkt_done, parity_err}, (i == 11) ? {1'b1, exp_pe} : 2'b00);
      end
    end
    read_enb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int vcnt = 0;
    int scnt = 0;
    int sat  = 0;
    bit done = 0;
    bit herr = 0;
    push(9'h104);
    read_enb = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (vld_out) vcnt++;
      if (soft_rst) begin scnt++; sat = i; end
      if (i == 32) begin
        nvec++;
        if ({fifo_rd_en, vld_out} !== 2'b00) begin nerr++; $display("FAIL tmo_srst_cycle: got rd_en,vld %b expected 00", {fifo_rd_en, vld_out}); end
      end
      if (i == 31) push(9'h100);
    end
    nvec++;
    if (vcnt != 30) begin nerr++; $display("FAIL tmo_vld_cycles: got %0d expected 30", vcnt); end
    nvec++;
    if (scnt != 1 || sat != 32) begin nerr++; $display("FAIL tmo_srst_pulse: got count %0d at %0d expected 1 at 32", scnt, sat); end
    push(9'h100); push(9'h000);
    read_enb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pkt_done) done = 1;
      if (hdr_err) herr = 1;
    end
    nvec++;
    if ({done, herr} !== 2'b10) begin nerr++; $display("FAIL tmo_recover: got done,hdr_err %b expected 10", {done, herr}); end
    read_enb = 1'b0;
  endtask

  task automatic test_timeout_priority();
    int vcnt = 0;
    bit done = 0;
    push(9'h100);
    read_enb = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (vld_out) vcnt++;
    end
    read_enb = 1'b1;
    @(negedge clk);
    nvec++;
    if ({soft_rst, vld_out} !== 2'b00) begin nerr++; $display("FAIL prio_accept: got srst,vld %b expected 00", {soft_rst, vld_out}); end
    @(negedge clk);
    nvec++;
    if (soft_rst !== 1'b0) begin nerr++; $display("FAIL prio_no_srst: got %b expected 0", soft_rst); end
    nvec++;
    if (vcnt != 30) begin nerr++; $display("FAIL prio_vld_cycles: got %0d expected 30", vcnt); end
    push(9'h000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pkt_done) done = 1;
    end
    nvec++;
    if (done !== 1'b1) begin nerr++; $display("FAIL prio_parity_done: got %b expected 1", done); end
    read_enb = 1'b0;
  endtask

  task automatic test_bad_header();
    push(9'h055);
    read_enb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      nvec++;
      if ({vld_out, hdr_err} !== {1'b0, (i == 2)}) begin
        nerr++;
        $display("FAIL badhdr[%0d]: got vld,hdr_err %b expected %b", i, {vld_out, hdr_err}, {1'b0, (i == 2)});
      end
    end
    read_enb = 1'b0;
  endtask

  task automatic test_truncated();
    logic [7:0] exp_b [4];
    logic       exp_v;
    exp_b = '{8'h08, 8'hAA, 8'h00, 8'h00};
    push(9'h108); push(9'h0AA); push(9'h100); push(9'h000);
    read_enb = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 0) && (i <= 8);
      nvec++;
      if ({vld_out, hdr_err, pkt_done, parity_err} !== {exp_v, (i == 6), (i == 9), 1'b0}) begin
        nerr++;
        $display("FAIL trunc_flags[%0d]: got %b expected %b", i, {vld_out, hdr_err, pkt_done, parity_err}, {exp_v, (i == 6), (i == 9), 1'b0});
      end
      if (exp_v) begin
        nvec++;
        if (data_out !== exp_b[i/2-1]) begin nerr++; $display("FAIL trunc_data[%0d]: got %h expected %h", i, data_out, exp_b[i/2-1]); end
      end
    end
    read_enb = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    bit done = 0;
    bit herr = 0;
    bit seen = 0;
    logic [7:0] first = 8'hFF;
    push(9'h10C); push(9'h011); push(9'h022);
    read_enb = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({vld_out, data_out} !== 9'h10C) begin nerr++; $display("FAIL rstmid_pre: got %h expected 10c", {vld_out, data_out}); end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({vld_out, data_out, fifo_rd_en, soft_rst, pkt_done, hdr_err, parity_err} !== 14'h0) begin
      nerr++;
      $display("FAIL rstmid_outputs: got %h expected 0", {vld_out, data_out, fifo_rd_en, soft_rst, pkt_done, hdr_err, parity_err});
    end
    rst = 1'b1;
    push(9'h100); push(9'h000);
    read_enb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld_out && !seen) begin seen = 1; first = data_out; end
      if (pkt_done) done = 1;
      if (hdr_err) herr = 1;
    end
    nvec++;
    if ({seen, first, done, herr} !== {1'b1, 8'h00, 2'b10}) begin
      nerr++;
      $display("FAIL rstmid_recover: got seen,byte,done,hdr_err %b,%h,%b,%b expected 1,00,1,0", seen, first, done, herr);
    end
    read_enb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_parity_err();
    test_timeout();
    test_timeout_priority();
    test_bad_header();
    test_truncated();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
